ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter in front of the single-port-per-direction ram block.
- Requester 0 is the CPU data port; requester 1 is the loader/debug port.
- Turns valid/ready requests into ram w_en/r_en strobes and returns read data with fixed latency.
- Supports a lock so one requester can do an atomic read-modify-write sequence, with a timeout that releases an abandoned lock.

Parameters:
- MEM_WIDTH, 16, data width; must match the ram instance.
- MEM_DEPTH, 256, word count; localparam ADDR_WIDTH = $clog2(MEM_DEPTH).
- LOCK_TIMEOUT, 16, number of consecutive idle owner cycles before a held lock is force-released (must be ≥1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_we  in  1  1 = write, 0 = read.
- req0_lock  in  1  keep ownership after this transfer.
- req0_addr  in  ADDR_WIDTH  word address.
- req0_wdata  in  MEM_WIDTH  write data.
- rsp0_valid  out  1  read data valid for requester 0.
- rsp0_rdata  out  MEM_WIDTH  read data.
- req1_valid, req1_ready, req1_we, req1_lock, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as requester 0, for requester 1.
- ram_w_en  out  1  to ram w_en.
- ram_r_en  out  1  to ram r_en.
- ram_w_addr  out  ADDR_WIDTH  to ram w_addr.
- ram_r_addr  out  ADDR_WIDTH  to ram r_addr.
- ram_w_data  out  MEM_WIDTH  to ram w_data.
- ram_r_data  in  MEM_WIDTH  from ram r_data (registered inside ram, 1-cycle latency).

Behaviour:
- Clocking and reset: all state updates on posedge clk. While rst_n = 0:
  - state = ARB, last_gnt = 1 (so requester 0 wins the first contention), lock timer = 0.
  - rsp0_valid = rsp1_valid = 0.
  - ram_w_en = ram_r_en = 0; all req*_ready = 0.
- Handshake: a transfer occurs when reqN_valid && reqN_ready in the same cycle. At most one transfer per cycle.
  - Requesters hold valid, we, addr, wdata and lock stable while valid && !ready.
  - The arbiter never drops an accepted request.
- Grant (combinational from the state and the current valids):
  - State ARB: if only one valid, grant it. If both valid, grant the one that is not last_gnt. last_gnt updates on every transfer.
  - State LOCKn: only requester n may be granted. The other requester's ready = 0.
- RAM drive (combinational from the granted request):
  - Write transfer: ram_w_en = 1; ram_w_addr = addr; ram_w_data = wdata.
  - Read transfer: ram_r_en = 1; ram_r_addr = addr.
  - No transfer: both enables = 0; the address and data outputs are don't-care but are driven from requester 0.
- Read response:
  - rspN_valid is registered: it is 1 exactly one cycle after a read transfer by N, otherwise 0.
  - rspN_rdata = ram_r_data (pass-through), so read latency is 1 cycle after acceptance.
  - Back-to-back reads give rsp_valid every cycle.
  - Writes produce no response.
- FSM states: ARB, LOCK0, LOCK1.
  - ARB -> LOCKn on a transfer by n with reqn_lock = 1.
  - LOCKn -> ARB on a transfer by n with reqn_lock = 0. That final transfer still completes.
  - LOCKn -> LOCKn on a transfer by n with lock = 1; the timer resets.
  - In LOCKn, each cycle with reqn_valid = 0 increments the timer. Any transfer by n clears it.
  - When the timer reaches LOCK_TIMEOUT, LOCKn -> ARB and the timer clears. The first grant in ARB after that follows normal round-robin.
- Simultaneous events:
  - Read and write to the same address by different requesters cannot happen in the same cycle (one transfer per cycle).
  - A write followed by a read of the same address on the next cycle returns the new data.
- Reset mid-operation:
  - A pending rsp_valid is cleared and not delivered.
  - Any held lock is dropped.
- Unused width: none. Address and data widths pass through unchanged.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with both valids high -> no ready, no ram enables, rsp*_valid = 0. After release, req0 is granted first.
- Single read: req1 writes 0xBEEF to addr 0x10, then reads 0x10 -> ram_w_en pulse with addr 0x10 and data 0xBEEF. Next, ram_r_en pulse; rsp1_valid = 1 one cycle later with rsp1_rdata = 0xBEEF; rsp0_valid stays 0.
- Contention: both valid continuously, reading addrs 0x01 (req0) and 0x02 (req1) -> grants alternate 0,1,0,1. Each rsp arrives 1 cycle after its grant. No cycle has two readys.
- Lock: req0 reads 0x20 with lock = 1, then writes 0x20 with lock = 0 while req1 is valid -> req1_ready = 0 until req0's write completes. req1 is granted the next cycle.
- Lock timeout: req0 takes the lock, then drops valid; req1 is valid -> req1 is blocked exactly LOCK_TIMEOUT = 16 cycles, then granted.
- Reset mid-read: assert rst_n = 0 the cycle after a req0 read is accepted -> rsp0_valid stays 0 and the lock state returns to ARB.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter with lock/timeout feeding a 1-cycle-latency RAM.
// Ready is combinational from state and valids; read response arrives 1 cycle after acceptance.
module ram_arbiter #(
  parameter int MEM_WIDTH    = 16,
  parameter int MEM_DEPTH    = 256,
  parameter int LOCK_TIMEOUT = 16,
  localparam int ADDR_WIDTH  = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic                  req0_lock,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [MEM_WIDTH-1:0]  req0_wdata,
  output logic                  rsp0_valid,
  output logic [MEM_WIDTH-1:0]  rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic                  req1_lock,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [MEM_WIDTH-1:0]  req1_wdata,
  output logic                  rsp1_valid,
  output logic [MEM_WIDTH-1:0]  rsp1_rdata,
  output logic                  ram_w_en,
  output logic                  ram_r_en,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic [ADDR_WIDTH-1:0] ram_r_addr,
  output logic [MEM_WIDTH-1:0]  ram_w_data,
  input  logic [MEM_WIDTH-1:0]  ram_r_data
);

  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

  state_t        state, state_nxt;
  logic          last_gnt, last_gnt_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          gnt0, gnt1;
  logic          rsp0_q, rsp1_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ARB;
      last_gnt <= 1'b1;
      timer    <= '0;
      rsp0_q   <= 1'b0;
      rsp1_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
      timer    <= timer_nxt;
      rsp0_q   <= gnt0 && !req0_we;
      rsp1_q   <= gnt1 && !req1_we;
    end
  end

  // Grants are forced low during reset so nothing reaches the RAM.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      case (state)
        ARB: begin
          gnt0 = req0_valid && (!req1_valid || last_gnt);
          gnt1 = req1_valid && (!req0_valid || !last_gnt);
        end
        LOCK0:   gnt0 = req0_valid;
        LOCK1:   gnt1 = req1_valid;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    last_gnt_nxt = last_gnt;
    if (gnt0)      last_gnt_nxt = 1'b0;
    else if (gnt1) last_gnt_nxt = 1'b1;
    case (state)
      ARB: begin
        timer_nxt = '0;
        if (gnt0 && req0_lock)      state_nxt = LOCK0;
        else if (gnt1 && req1_lock) state_nxt = LOCK1;
      end
      LOCK0: begin
        if (gnt0) begin
          timer_nxt = '0;
          if (!req0_lock) state_nxt = ARB;
        end else if (!req0_valid) begin
          if (timer == TIMER_LAST) begin
            state_nxt = ARB;
            timer_nxt = '0;
          end else begin
            timer_nxt = timer + TW'(1);
          end
        end
      end
      LOCK1: begin
        if (gnt1) begin
          timer_nxt = '0;
          if (!req1_lock) state_nxt = ARB;
        end else if (!req1_valid) begin
          if (timer == TIMER_LAST) begin
            state_nxt = ARB;
            timer_nxt = '0;
          end else begin
            timer_nxt = timer + TW'(1);
          end
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign ram_w_en   = (gnt0 && req0_we) || (gnt1 && req1_we);
  assign ram_r_en   = (gnt0 && !req0_we) || (gnt1 && !req1_we);
  assign ram_w_addr = gnt1 ? req1_addr  : req0_addr;
  assign ram_r_addr = gnt1 ? req1_addr  : req0_addr;
  assign ram_w_data = gnt1 ? req1_wdata : req0_wdata;

  // Masking with rst_n drops a response that was in flight when reset hit.
  assign rsp0_valid = rsp0_q && rst_n;
  assign rsp1_valid = rsp1_q && rst_n;
  assign rsp0_rdata = ram_r_data;
  assign rsp1_rdata = ram_r_data;

endmodule
